// File: rtl/iter_muldiv_pkg.sv
// rtl/iter_muldiv_pkg.sv - shared types and constants for the iterative mul/div engine
// Contents: state_t (IDLE, LOAD, RUN, DONE), op encodings OP_MUL/OP_DIV,
//           default WIDTH/CNT_WIDTH values.
package iter_muldiv_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH = 8;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/iter_muldiv_ctrl.sv
// rtl/iter_muldiv_ctrl.sv - sequencing FSM, iteration counter and cap detect
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, honoured only in IDLE
//   dbz_load        captured op is a divide by zero (evaluated in LOAD)
//   term            datapath loop-termination condition (evaluated in RUN)
//   state           current FSM state
//   cnt             iterations executed in the current op
//   busy, done      registered status (busy in LOAD/RUN, done pulse in DONE)
//   accept          start accepted this cycle
//   step            datapath performs one iteration this cycle
//   cap_stop        loop stopped by the iteration cap this cycle
//   finish          moving to DONE on this edge; datapath latches outputs
module iter_muldiv_ctrl
  import iter_muldiv_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dbz_load,
  input  logic                 term,
  output state_t               state,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 accept,
  output logic                 step,
  output logic                 cap_stop,
  output logic                 finish
);

  logic at_cap;

  assign at_cap   = (cnt == {CNT_WIDTH{1'b1}});
  assign accept   = (state == IDLE) && start;
  // Termination wins over the cap: a loop ending exactly at the cap is not an overflow.
  assign step     = (state == RUN) && !term && !at_cap;
  assign cap_stop = (state == RUN) && !term && at_cap;
  assign finish   = ((state == LOAD) && dbz_load) || ((state == RUN) && (term || at_cap));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (dbz_load) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (term || at_cap) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// rtl/iter_muldiv_unit.sv - iterative multiply (repeated add) / divide (repeated subtract) engine
// Optional feature macro: ITER_MULDIV_OPSWAP_EN (multiply loops over min(a,b)).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        request, sampled only in IDLE
//   op           0 = multiply, 1 = divide
//   a, b         multiplicand/dividend, multiplier/divisor
//   busy         high in LOAD and RUN
//   done         one-cycle pulse in DONE
//   result       product or quotient
//   remainder    divide remainder, 0 for multiply
//   iter_count   iterations of the last/current op (live while active)
//   ovf          product carry-out or iteration cap reached
//   dbz          divide by zero
module iter_muldiv_unit
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     remainder,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic                 ovf,
  output logic                 dbz
);

  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 op_op;
  logic [WIDTH-1:0]     acc;   // product accumulator (mul) or quotient (div)
  logic [WIDTH-1:0]     rem;   // loop countdown (mul) or running remainder (div)
  logic [WIDTH:0]       mul_sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] iter_hold;
  state_t               state;
  logic                 accept;
  logic                 step;
  logic                 cap_stop;
  logic                 finish;
  logic                 term;
  logic                 dbz_load;

  assign mul_sum  = {1'b0, acc} + {1'b0, op_a};
  assign term     = (op_op == OP_MUL) ? (rem == '0) : (rem < op_b);
  assign dbz_load = (op_op == OP_DIV) && (op_b == '0);

  // Counter is shown live while an op is in flight, otherwise the last op's final count.
  assign iter_count = (state == IDLE) ? iter_hold : cnt;

  iter_muldiv_ctrl #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dbz_load (dbz_load),
    .term     (term),
    .state    (state),
    .cnt      (cnt),
    .busy     (busy),
    .done     (done),
    .accept   (accept),
    .step     (step),
    .cap_stop (cap_stop),
    .finish   (finish)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      op_op     <= OP_MUL;
      acc       <= '0;
      rem       <= '0;
      result    <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      iter_hold <= '0;
    end else begin
      if (accept) begin
        op_a  <= a;
        op_b  <= b;
        op_op <= op;
        acc   <= '0;
        ovf   <= 1'b0;
        dbz   <= 1'b0;
      end

      if (state == LOAD) begin
        acc <= '0;
        if (op_op == OP_MUL) begin
`ifdef ITER_MULDIV_OPSWAP_EN
          // Count down the smaller operand and add the larger one.
          if (op_a < op_b) begin
            rem  <= op_a;
            op_a <= op_b;
          end else begin
            rem <= op_b;
          end
`else
          rem <= op_b;
`endif
        end else if (!dbz_load) begin
          rem <= op_a;
        end else begin
          dbz <= 1'b1;
        end
      end

      if (step) begin
        if (op_op == OP_MUL) begin
          acc <= mul_sum[WIDTH-1:0];
          rem <= rem - 1'b1;
          if (mul_sum[WIDTH]) begin
            ovf <= 1'b1;
          end
        end else begin
          acc <= acc + 1'b1;
          rem <= rem - op_b;
        end
      end

      if (cap_stop) begin
        ovf <= 1'b1;
      end

      if (finish) begin
        if (state == LOAD) begin
          result    <= '1;
          remainder <= op_a;
        end else begin
          result    <= acc;
          remainder <= (op_op == OP_MUL) ? '0 : rem;
        end
      end

      if (state == DONE) begin
        iter_hold <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// tb/tb_iter_muldiv_unit.sv - directed self-checking bench for iter_muldiv_unit
module tb_iter_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] remainder;
  logic [7:0]  iter_count;
  logic        ovf;
  logic        dbz;

  int checks;
  int passed;

  // Results of the most recent run_op call
  int          r_wait;
  int          r_lat;
  logic [15:0] r_res;
  logic [15:0] r_rem;
  logic [7:0]  r_it;
  logic        r_ovf;
  logic        r_dbz;

  iter_muldiv_unit #(
    .WIDTH     (16),
    .CNT_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .remainder  (remainder),
    .iter_count (iter_count),
    .ovf        (ovf),
    .dbz        (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start until the unit goes busy (r_wait = edges taken), scramble the
  // inputs, then count edges (r_lat) until done; optionally re-pulse start at poke.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic iop, input int poke);
    a = ia;
    b = ib;
    op = iop;
    start = 1'b1;
    r_wait = 0;
    do begin
      @(posedge clk);
      #1;
      r_wait++;
    end while (!busy && r_wait < 10);
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    op = ~iop;
    r_lat = 0;
    while (!done && r_lat < 1000) begin
      if (poke != 0) start = (r_lat == poke);
      @(posedge clk);
      #1;
      r_lat++;
    end
    start = 1'b0;
    if (!done) r_lat = -1;
    r_res = result;
    r_rem = remainder;
    r_it  = iter_count;
    r_ovf = ovf;
    r_dbz = dbz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = 16'd0;
    b = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0d want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %0d want 0", done); else passed++;
    checks++; if (result !== 16'd0) $display("FAIL reset_result got %0d want 0", result); else passed++;
    checks++; if (remainder !== 16'd0) $display("FAIL reset_remainder got %0d want 0", remainder); else passed++;
    checks++; if (iter_count !== 8'd0) $display("FAIL reset_iter got %0d want 0", iter_count); else passed++;
    checks++; if ({ovf, dbz} !== 2'b00) $display("FAIL reset_flags got %b want 00", {ovf, dbz}); else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_basic();
    run_op(16'd7, 16'd5, 1'b0, 0);
    checks++; if (r_wait !== 1) $display("FAIL mul75_accept got %0d want 1", r_wait); else passed++;
    checks++; if (r_lat !== 7) $display("FAIL mul75_latency got %0d want 7", r_lat); else passed++;
    checks++; if (r_res !== 16'd35) $display("FAIL mul75_result got %0d want 35", r_res); else passed++;
    checks++; if (r_rem !== 16'd0) $display("FAIL mul75_remainder got %0d want 0", r_rem); else passed++;
    checks++; if (r_it !== 8'd5) $display("FAIL mul75_iter got %0d want 5", r_it); else passed++;
    checks++; if ({r_ovf, r_dbz} !== 2'b00) $display("FAIL mul75_flags got %b want 00", {r_ovf, r_dbz}); else passed++;
    @(posedge clk);
    #1;
    checks++; if ({done, busy} !== 2'b00) $display("FAIL mul75_done_pulse got %b want 00", {done, busy}); else passed++;
    checks++; if (result !== 16'd35 || iter_count !== 8'd5) $display("FAIL mul75_hold got %0d/%0d want 35/5", result, iter_count); else passed++;
  endtask

  task automatic test_div_and_back_to_back();
    run_op(16'd100, 16'd7, 1'b1, 0);
    checks++; if (r_lat !== 16) $display("FAIL div100_7_latency got %0d want 16", r_lat); else passed++;
    checks++; if (r_res !== 16'd14) $display("FAIL div100_7_result got %0d want 14", r_res); else passed++;
    checks++; if (r_rem !== 16'd2) $display("FAIL div100_7_remainder got %0d want 2", r_rem); else passed++;
    checks++; if (r_it !== 8'd14) $display("FAIL div100_7_iter got %0d want 14", r_it); else passed++;
    // start already high in DONE must wait for IDLE before it is accepted
    run_op(16'd3, 16'd9, 1'b1, 0);
    checks++; if (r_wait !== 2) $display("FAIL b2b_accept_edges got %0d want 2", r_wait); else passed++;
    checks++; if (r_lat !== 2) $display("FAIL div3_9_latency got %0d want 2", r_lat); else passed++;
    checks++; if (r_res !== 16'd0) $display("FAIL div3_9_result got %0d want 0", r_res); else passed++;
    checks++; if (r_rem !== 16'd3) $display("FAIL div3_9_remainder got %0d want 3", r_rem); else passed++;
    checks++; if (r_it !== 8'd0) $display("FAIL div3_9_iter got %0d want 0", r_it); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_by_zero();
    run_op(16'd50, 16'd0, 1'b1, 0);
    checks++; if (r_lat !== 1) $display("FAIL dbz_latency got %0d want 1", r_lat); else passed++;
    checks++; if (r_dbz !== 1'b1) $display("FAIL dbz_flag got %0d want 1", r_dbz); else passed++;
    checks++; if (r_res !== 16'hFFFF) $display("FAIL dbz_result got %h want ffff", r_res); else passed++;
    checks++; if (r_rem !== 16'd50) $display("FAIL dbz_remainder got %0d want 50", r_rem); else passed++;
    checks++; if (r_it !== 8'd0) $display("FAIL dbz_iter got %0d want 0", r_it); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    run_op(16'd1, 16'd300, 1'b0, 0);
    checks++; if (r_dbz !== 1'b0) $display("FAIL cap_dbz_cleared got %0d want 0", r_dbz); else passed++;
    checks++; if (r_lat !== 257) $display("FAIL cap_latency got %0d want 257", r_lat); else passed++;
    checks++; if (r_ovf !== 1'b1) $display("FAIL cap_ovf got %0d want 1", r_ovf); else passed++;
    checks++; if (r_res !== 16'd255) $display("FAIL cap_result got %0d want 255", r_res); else passed++;
    checks++; if (r_it !== 8'd255) $display("FAIL cap_iter got %0d want 255", r_it); else passed++;
    @(posedge clk);
    #1;
    run_op(16'h8000, 16'd2, 1'b0, 0);
    checks++; if (r_lat !== 4) $display("FAIL carry_latency got %0d want 4", r_lat); else passed++;
    checks++; if (r_ovf !== 1'b1) $display("FAIL carry_ovf got %0d want 1", r_ovf); else passed++;
    checks++; if (r_res !== 16'd0) $display("FAIL carry_result got %0d want 0", r_res); else passed++;
    checks++; if (r_it !== 8'd2) $display("FAIL carry_iter got %0d want 2", r_it); else passed++;
    @(posedge clk);
    #1;
    run_op(16'd6, 16'd3, 1'b0, 0);
    checks++; if (r_ovf !== 1'b0 || r_res !== 16'd18) $display("FAIL ovf_cleared got ovf=%0d res=%0d want ovf=0 res=18", r_ovf, r_res); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_while_busy();
    run_op(16'd4, 16'd6, 1'b0, 3);
    checks++; if (r_lat !== 8) $display("FAIL busy_start_latency got %0d want 8", r_lat); else passed++;
    checks++; if (r_res !== 16'd24) $display("FAIL busy_start_result got %0d want 24", r_res); else passed++;
    checks++; if (r_it !== 8'd6) $display("FAIL busy_start_iter got %0d want 6", r_it); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL busy_start_retrigger got %0d want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_run();
    bit seen_done;
    a = 16'd3;
    b = 16'd20;
    op = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || iter_count !== 8'd5) $display("FAIL midrun_live_iter got busy=%0d iter=%0d want busy=1 iter=5", busy, iter_count); else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL midrun_rst_status got %b want 00", {busy, done}); else passed++;
    checks++; if (result !== 16'd0 || remainder !== 16'd0) $display("FAIL midrun_rst_data got %0d/%0d want 0/0", result, remainder); else passed++;
    checks++; if (iter_count !== 8'd0 || {ovf, dbz} !== 2'b00) $display("FAIL midrun_rst_iter_flags got %0d/%b want 0/00", iter_count, {ovf, dbz}); else passed++;
    seen_done = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) $display("FAIL midrun_no_done got %0d want 0", seen_done); else passed++;
  endtask

  task automatic test_opswap();
    int exp_n;
`ifdef ITER_MULDIV_OPSWAP_EN
    exp_n = 2;
`else
    exp_n = 200;
`endif
    run_op(16'd2, 16'd200, 1'b0, 0);
    checks++; if (r_res !== 16'd400) $display("FAIL opswap_result got %0d want 400", r_res); else passed++;
    checks++; if (int'(r_it) !== exp_n) $display("FAIL opswap_iter got %0d want %0d", r_it, exp_n); else passed++;
    checks++; if (r_lat !== exp_n + 2) $display("FAIL opswap_latency got %0d want %0d", r_lat, exp_n + 2); else passed++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_mul_basic();
    test_reset_mid_run();
    test_div_and_back_to_back();
    test_div_by_zero();
    test_overflow();
    test_start_while_busy();
    test_opswap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/iter_muldiv_unit.md
Name: iter_muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine.
- Multiply by repeated addition; divide by repeated subtraction.
- Built-in iteration-cap guard stops runaway loops.
- Sits between the operand registers (ROM-fed A/B) and the result registers; replaces the ad-hoc controller/mux/loop-guard arrangement with one handshaked block.

Parameters:
- WIDTH, 16, operand/result/remainder width.
- CNT_WIDTH, 8, iteration counter width; cap = 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- busy  output  1  high in LOAD and RUN
- done  output  1  one-cycle pulse in DONE
- result  output  WIDTH  product (mul) or quotient (div)
- remainder  output  WIDTH  div remainder; 0 for mul
- iter_count  output  CNT_WIDTH  iterations executed in last/current op
- ovf  output  1  mul product exceeded WIDTH, or iteration cap hit
- dbz  output  1  divide by zero

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (clk, rst). Reset is fixed at this polarity and synchronicity.
- Reset: state IDLE; busy, done, ovf, dbz = 0; result, remainder, iter_count = 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 on an edge -> LOAD.
  - a, b, op captured into internal opA, opB, opOp.
  - acc, cnt, ovf, dbz cleared.
  - start=0 -> stay in IDLE.
- LOAD (1 cycle):
  - Mul: acc=0, rem=opB -> RUN.
  - Div, opB≠0: rem=opA, quot=0 -> RUN.
  - Div, opB=0: dbz=1, result=all ones, remainder=opA -> DONE.
- RUN, one step per cycle. The termination check takes priority over the update.
  - Mul terminate: rem==0. Update: acc+=opA (WIDTH-bit wrap; ovf sticky on carry-out), rem-=1, cnt+=1.
  - Div terminate: rem<opB. Update: rem-=opB, quot+=1 (WIDTH bits), cnt+=1.
  - Cap: if cnt==2^CNT_WIDTH-1 and not terminating -> set ovf and go to DONE. Partial acc/quot and rem are kept.
- DONE (1 cycle):
  - done=1; result/remainder/iter_count updated this cycle; -> IDLE.
- Latency:
  - done is high in the cycle after the (N+2)-th edge following the edge that sampled start, where N = iterations executed.
  - Mul: N=b. Div: N=floor(a/b). Capped: N = 2^CNT_WIDTH-1.
  - Div-by-zero: done in the cycle after the 2nd edge.
- Outputs hold until the next DONE (or reset). iter_count tracks cnt live while busy.
- start while busy: ignored. start held high in DONE: does not retrigger; it is re-sampled in IDLE on the next edge.
- Inputs a/b/op may change freely after the start edge; only captured values are used.
- rst mid-operation: immediate IDLE, all outputs cleared, no done pulse.
- Unsigned arithmetic throughout.

Optional Feature:
- Macro: ITER_MULDIV_OPSWAP_EN.
- Defined: in LOAD, mul swaps operands so the loop counts min(a,b) and adds max(a,b). Product is unchanged; N = min(a,b).
- Undefined: N=b always, as specified above.
- Div is unaffected in both cases.

Decomposition:
- Package iter_muldiv_pkg:
  - state enum (IDLE, LOAD, RUN, DONE).
  - op encodings OP_MUL=0, OP_DIV=1.
  - default WIDTH/CNT_WIDTH localparams.
- One sub-module, iter_muldiv_ctrl: FSM plus iteration counter and cap detect.
- Datapath (acc/rem/quot registers, adder/subtractor) stays in the top level.

Test Plan:
- Mul a=7, b=5, WIDTH=16 -> done after 7 edges; result=35, remainder=0, iter_count=5, ovf=0.
- Div a=100, b=7 -> result=14, remainder=2, iter_count=14; div a=3, b=9 -> result=0, remainder=3, iter_count=0.
- Div a=50, b=0 -> dbz=1, result=16'hFFFF, remainder=50, done 2 edges after start; no RUN cycles.
- Mul a=1, b=300, CNT_WIDTH=8 -> cap at 255: ovf=1, result=255, iter_count=255. Mul a=16'h8000, b=2 -> ovf=1, result=0.
- Assert rst mid-RUN (mul a=3, b=20, after 5 iterations) -> next cycle IDLE, all outputs 0, no done. Pulse start during busy -> ignored; the op completes with the original operands.
- With ITER_MULDIV_OPSWAP_EN: mul a=2, b=200 -> iter_count=2, result=400; without the macro -> iter_count=200.
